// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB-Lite arbiter with round-robin grant, fixed-length burst locking,
// and address/control/write-data multiplexing onto the shared slave port.
module ahb_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [1:0]        HBUSREQ,
  output logic [1:0]        HGRANT,
  output logic              HMASTER,
  output logic              HMASTER_DATA,
  input  logic [1:0]        HTRANS_M0,
  input  logic [1:0]        HTRANS_M1,
  input  logic [2:0]        HBURST_M0,
  input  logic [2:0]        HBURST_M1,
  input  logic [2:0]        HSIZE_M0,
  input  logic [2:0]        HSIZE_M1,
  input  logic              HWRITE_M0,
  input  logic              HWRITE_M1,
  input  logic [ADDR_W-1:0] HADDR_M0,
  input  logic [ADDR_W-1:0] HADDR_M1,
  input  logic [DATA_W-1:0] HWDATA_M0,
  input  logic [DATA_W-1:0] HWDATA_M1,
  input  logic              HREADY,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HBURST,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [ADDR_W-1:0] HADDR,
  output logic [DATA_W-1:0] HWDATA
);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [1:0] GRANT_RST  = (DEFAULT_MASTER == 0) ? 2'b01 : 2'b10;
  localparam logic       MASTER_RST = (DEFAULT_MASTER != 0);

  typedef enum logic {ARB, LOCKED} arb_state_t;

  logic [1:0] r_hgrant;
  logic       r_hmaster;
  logic       r_hmaster_data;
  logic [3:0] r_beats_left;

  logic [3:0] w_beats_next;
  logic [1:0] w_grant_next;
  arb_state_t w_arb_state;

  assign HTRANS = r_hmaster ? HTRANS_M1 : HTRANS_M0;
  assign HBURST = r_hmaster ? HBURST_M1 : HBURST_M0;
  assign HSIZE  = r_hmaster ? HSIZE_M1  : HSIZE_M0;
  assign HWRITE = r_hmaster ? HWRITE_M1 : HWRITE_M0;
  assign HADDR  = r_hmaster ? HADDR_M1  : HADDR_M0;
  assign HWDATA = r_hmaster_data ? HWDATA_M1 : HWDATA_M0;

  assign HGRANT       = r_hgrant;
  assign HMASTER      = r_hmaster;
  assign HMASTER_DATA = r_hmaster_data;

  // Remaining beats after the current address phase is accepted; INCR never locks.
  always_comb begin
    w_beats_next = r_beats_left;
    case (HTRANS)
      TRANS_NONSEQ: begin
        case (HBURST)
          3'd2, 3'd3: w_beats_next = 4'd3;
          3'd4, 3'd5: w_beats_next = 4'd7;
          3'd6, 3'd7: w_beats_next = 4'd15;
          default:    w_beats_next = '0;
        endcase
      end
      TRANS_SEQ:  w_beats_next = (r_beats_left != '0) ? r_beats_left - 4'd1 : '0;
      TRANS_BUSY: w_beats_next = r_beats_left;
      TRANS_IDLE: w_beats_next = '0;
      default:    w_beats_next = r_beats_left;
    endcase
  end

  assign w_arb_state = (w_beats_next == '0) ? ARB : LOCKED;

  always_comb begin
    w_grant_next = r_hgrant;
    case (HBUSREQ)
      2'b01:   w_grant_next = 2'b01;
      2'b10:   w_grant_next = 2'b10;
      2'b11:   w_grant_next = {r_hgrant[0], r_hgrant[1]};
      default: w_grant_next = r_hgrant;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_hgrant       <= GRANT_RST;
      r_hmaster      <= MASTER_RST;
      r_hmaster_data <= MASTER_RST;
      r_beats_left   <= '0;
    end else if (HREADY) begin
      r_beats_left   <= w_beats_next;
      r_hmaster      <= r_hgrant[1];
      r_hmaster_data <= r_hmaster;
      if (w_arb_state == ARB) begin
        r_hgrant <= w_grant_next;
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter: reset, single requester,
// contention, burst lock, wait states, early termination and mid-burst reset.
module tb_ahb_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [1:0]        HBUSREQ;
  logic [1:0]        HGRANT;
  logic              HMASTER;
  logic              HMASTER_DATA;
  logic [1:0]        HTRANS_M0, HTRANS_M1;
  logic [2:0]        HBURST_M0, HBURST_M1;
  logic [2:0]        HSIZE_M0, HSIZE_M1;
  logic              HWRITE_M0, HWRITE_M1;
  logic [ADDR_W-1:0] HADDR_M0, HADDR_M1;
  logic [DATA_W-1:0] HWDATA_M0, HWDATA_M1;
  logic              HREADY;
  logic [1:0]        HTRANS;
  logic [2:0]        HBURST;
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic [ADDR_W-1:0] HADDR;
  logic [DATA_W-1:0] HWDATA;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ahb_bus_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEFAULT_MASTER(0)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HGRANT(HGRANT),
    .HMASTER(HMASTER), .HMASTER_DATA(HMASTER_DATA),
    .HTRANS_M0(HTRANS_M0), .HTRANS_M1(HTRANS_M1),
    .HBURST_M0(HBURST_M0), .HBURST_M1(HBURST_M1),
    .HSIZE_M0(HSIZE_M0), .HSIZE_M1(HSIZE_M1),
    .HWRITE_M0(HWRITE_M0), .HWRITE_M1(HWRITE_M1),
    .HADDR_M0(HADDR_M0), .HADDR_M1(HADDR_M1),
    .HWDATA_M0(HWDATA_M0), .HWDATA_M1(HWDATA_M1),
    .HREADY(HREADY),
    .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HADDR(HADDR), .HWDATA(HWDATA)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    logic [1:0] exp_gnt [4];
    logic       exp_mst [4];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_mst = '{1'b1, 1'b0, 1'b1, 1'b0};

    HRESET    = 1'b1;
    HBUSREQ   = 2'b00;
    HTRANS_M0 = 2'd0;  HTRANS_M1 = 2'd0;
    HBURST_M0 = 3'd0;  HBURST_M1 = 3'd0;
    HSIZE_M0  = 3'd2;  HSIZE_M1  = 3'd2;
    HWRITE_M0 = 1'b1;  HWRITE_M1 = 1'b0;
    HADDR_M0  = 32'hA0; HADDR_M1 = 32'hB0;
    HWDATA_M0 = 32'hD0; HWDATA_M1 = 32'hD1;
    HREADY    = 1'b1;

    tick();
    tick();
    check_eq("rst_grant",   HGRANT, 2'b01);
    check_eq("rst_master",  HMASTER, 1'b0);
    check_eq("rst_mdata",   HMASTER_DATA, 1'b0);
    check_eq("rst_haddr",   HADDR, 32'hA0);
    check_eq("rst_beats",   dut.r_beats_left, 4'd0);
    HRESET = 1'b0;

    // Single requester: m1 only
    HBUSREQ = 2'b10;
    tick();
    check_eq("single_grant", HGRANT, 2'b10);
    check_eq("single_mst_e1", HMASTER, 1'b0);
    tick();
    check_eq("single_mst_e2", HMASTER, 1'b1);
    check_eq("single_haddr", HADDR, 32'hB0);
    check_eq("single_hwdata_e2", HWDATA, 32'hD0);
    tick();
    check_eq("single_mdata", HMASTER_DATA, 1'b1);
    check_eq("single_hwdata_e3", HWDATA, 32'hD1);

    // Contention with SINGLE transfers from both masters
    HBUSREQ   = 2'b11;
    HTRANS_M0 = 2'd2; HBURST_M0 = 3'd0;
    HTRANS_M1 = 2'd2; HBURST_M1 = 3'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq($sformatf("rr_grant_%0d", i), HGRANT, exp_gnt[i]);
      check_eq($sformatf("rr_master_%0d", i), HMASTER, exp_mst[i]);
    end

    // Hand bus to m0 before the burst-lock test
    HBUSREQ   = 2'b01;
    HTRANS_M0 = 2'd0; HTRANS_M1 = 2'd0;
    tick();
    tick();
    check_eq("pre_lock_master", HMASTER, 1'b0);

    // Burst lock: m0 INCR8 at 0x100, m1 requests from beat 2
    HTRANS_M0 = 2'd2; HBURST_M0 = 3'd5; HADDR_M0 = 32'h100;
    tick();
    check_eq("lock_b1_beats", dut.r_beats_left, 4'd7);
    check_eq("lock_b1_grant", HGRANT, 2'b01);
    HBUSREQ   = 2'b11;
    HTRANS_M0 = 2'd3;
    for (int b = 2; b <= 8; b++) begin
      HADDR_M0 = 32'h100 + 32'((b - 1) * 4);
      tick();
      check_eq($sformatf("lock_b%0d_beats", b), dut.r_beats_left, 4'(8 - b));
      check_eq($sformatf("lock_b%0d_grant", b), HGRANT, (b == 8) ? 2'b10 : 2'b01);
    end
    HTRANS_M0 = 2'd0;
    HBUSREQ   = 2'b10;
    tick();
    check_eq("lock_handover_master", HMASTER, 1'b1);
    check_eq("lock_handover_haddr", HADDR, 32'hB0);
    check_eq("lock_handover_grant", HGRANT, 2'b10);

    // Wait states during m1 WRAP4
    HTRANS_M1 = 2'd2; HBURST_M1 = 3'd2;
    tick();
    check_eq("wrap_b1_beats", dut.r_beats_left, 4'd3);
    HTRANS_M1 = 2'd3;
    tick();
    check_eq("wrap_b2_beats", dut.r_beats_left, 4'd2);
    HREADY  = 1'b0;
    HBUSREQ = 2'b11;
    for (int w = 0; w < 3; w++) begin
      tick();
      check_eq($sformatf("wrap_wait%0d_beats", w), dut.r_beats_left, 4'd2);
      check_eq($sformatf("wrap_wait%0d_grant", w), HGRANT, 2'b10);
      check_eq($sformatf("wrap_wait%0d_master", w), HMASTER, 1'b1);
    end
    HREADY = 1'b1;
    tick();
    check_eq("wrap_b3_beats", dut.r_beats_left, 4'd1);
    check_eq("wrap_b3_grant", HGRANT, 2'b10);
    tick();
    check_eq("wrap_b4_beats", dut.r_beats_left, 4'd0);
    check_eq("wrap_b4_grant", HGRANT, 2'b01);
    HTRANS_M1 = 2'd0;
    HBUSREQ   = 2'b01;
    tick();
    check_eq("wrap_after_master", HMASTER, 1'b0);
    check_eq("wrap_after_grant", HGRANT, 2'b01);

    // Early termination: m0 INCR16, IDLE after beat 3 while m1 requests
    HTRANS_M0 = 2'd2; HBURST_M0 = 3'd7; HADDR_M0 = 32'h200;
    tick();
    check_eq("early_b1_beats", dut.r_beats_left, 4'd15);
    HBUSREQ   = 2'b11;
    HTRANS_M0 = 2'd3;
    tick();
    tick();
    check_eq("early_b3_beats", dut.r_beats_left, 4'd13);
    check_eq("early_b3_grant", HGRANT, 2'b01);
    HTRANS_M0 = 2'd0;
    tick();
    check_eq("early_idle_beats", dut.r_beats_left, 4'd0);
    check_eq("early_idle_grant", HGRANT, 2'b10);

    // Asynchronous reset mid-INCR8 owned by m1
    HBUSREQ  = 2'b10;
    HADDR_M0 = 32'hA0;
    tick();
    check_eq("mrst_pre_master", HMASTER, 1'b1);
    HTRANS_M1 = 2'd2; HBURST_M1 = 3'd5;
    tick();
    HTRANS_M1 = 2'd3;
    tick();
    check_eq("mrst_pre_beats", dut.r_beats_left, 4'd6);
    #2;
    HRESET = 1'b1;
    #1;
    check_eq("mrst_grant",  HGRANT, 2'b01);
    check_eq("mrst_master", HMASTER, 1'b0);
    check_eq("mrst_mdata",  HMASTER_DATA, 1'b0);
    check_eq("mrst_haddr",  HADDR, 32'hA0);
    check_eq("mrst_beats",  dut.r_beats_left, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
